// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump path: FSM states, default widths
// and the architectural register index type used by the regfile and debug path.
package regfile_dump_pkg;

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  typedef logic [AW_DEF-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks registers first..last (wrapping) through one read port, one word per 2 cycles best case;
// first word valid 2 edges after start, each word held stable until out_ready, abort drops to IDLE.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  dump_state_t   state;
  logic [AW-1:0] cursor;
  logic [AW-1:0] last_q;

  // Explicit wrap so non-power-of-two register counts still walk modulo NREGS.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] cur);
    if (cur == LAST_REG) return '0;
    return cur + 1'b1;
  endfunction

  // Driven from the cursor in every state so the external read-port mux never sees a glitch.
  assign rf_addr = cursor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      cursor    <= '0;
      last_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cursor <= first_idx;
            last_q <= last_idx;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end

        FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            out_data  <= rf_data;
            out_idx   <= cursor;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            // A handshake completing on this edge still counts as delivered.
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (cursor == last_q) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              cursor <= next_idx(cursor);
              state  <= FETCH;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file behind the read port.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        busy;
  logic        done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;

  logic [31:0] rf [32];
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  logic [4:0]  q_idx [$];
  logic [31:0] q_dat [$];
  int          n_done;
  int          n_busy;

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  always @(posedge clk) begin
    if (we) rf[wa] <= wd;
  end

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  // Starts a dump and collects every accepted word until busy falls.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l);
    q_idx.delete();
    q_dat.delete();
    n_done = 0;
    n_busy = 0;
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (busy) n_busy++;
      if (done) n_done++;
      if (out_valid && out_ready) begin
        q_idx.push_back(out_idx);
        q_dat.push_back(out_data);
      end
      if (!busy) break;
      step();
    end
    chk("dump_terminates", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] exp_d;
  logic [4:0]  exp_i;
  logic [31:0] held_d;
  logic [4:0]  held_i;
  int          acc;
  int          cyc;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_idx = '0; last_idx = '0; we = 1'b0; wa = '0; wd = '0;
    step();
    step();
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_idx",   {27'd0, out_idx},   32'd0);
    chk("rst_rf_addr",   {27'd0, rf_addr},   32'd0);

    for (int i = 0; i < 32; i++) wr(5'(i), 32'd0);
    wr(5'd5,  32'hDEADBEEF);
    wr(5'd17, 32'h12345678);
    reset = 1'b0;
    step();

    // Full dump 0..31 with the sink always ready.
    run_dump(5'd0, 5'd31);
    chk("full_count", q_idx.size(), 32'd32);
    chk("full_done",  n_done,       32'd1);
    chk("full_busy_cycles", n_busy, 32'd65);
    if (q_idx.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        exp_d = (i == 5) ? 32'hDEADBEEF : (i == 17) ? 32'h12345678 : 32'd0;
        chk($sformatf("full_idx%0d", i),  {27'd0, q_idx[i]}, 32'(i));
        chk($sformatf("full_data%0d", i), q_dat[i],          exp_d);
      end
    end

    // Wrapping range 30..1.
    run_dump(5'd30, 5'd1);
    chk("wrap_count", q_idx.size(), 32'd4);
    chk("wrap_done",  n_done,       32'd1);
    if (q_idx.size() == 4) begin
      chk("wrap_idx0", {27'd0, q_idx[0]}, 32'd30);
      chk("wrap_idx1", {27'd0, q_idx[1]}, 32'd31);
      chk("wrap_idx2", {27'd0, q_idx[2]}, 32'd0);
      chk("wrap_idx3", {27'd0, q_idx[3]}, 32'd1);
    end

    // Single word first==last.
    wr(5'd7, 32'h00000777);
    run_dump(5'd7, 5'd7);
    chk("one_count", q_idx.size(), 32'd1);
    chk("one_done",  n_done,       32'd1);
    if (q_idx.size() == 1) begin
      chk("one_idx",  {27'd0, q_idx[0]}, 32'd7);
      chk("one_data", q_dat[0],          32'h00000777);
    end

    // Backpressure on idx2, with start and changed range pulsed mid-dump.
    wr(5'd2, 32'h22222222);
    out_ready = 1'b0;
    first_idx = 5'd2; last_idx = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    chk("bp_idx",        {27'd0, out_idx},   32'd2);
    chk("bp_data",       out_data,           32'h22222222);
    held_d = out_data;
    held_i = out_idx;
    first_idx = 5'd20; last_idx = 5'd25; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    chk("bp_data_held",  out_data,           held_d);
    chk("bp_idx_held",   {27'd0, out_idx},   {27'd0, held_i});
    out_ready = 1'b1;
    acc = 0; n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) acc++;
      if (done) n_done++;
      if (!busy) break;
      step();
    end
    chk("bp_accepted", acc,    32'd1);
    chk("bp_done",     n_done, 32'd1);
    chk("bp_idle",     {31'd0, busy}, 32'd0);

    // Same-edge write to x3 while FETCH samples it.
    first_idx = 5'd3; last_idx = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    step();
    we = 1'b0;
    chk("race_idx",  {27'd0, out_idx}, 32'd3);
    chk("race_data", out_data,         32'd0);
    for (int c = 0; c < 10 && busy; c++) step();
    run_dump(5'd3, 5'd3);
    chk("race_later_count", q_idx.size(), 32'd1);
    if (q_dat.size() == 1) chk("race_later_data", q_dat[0], 32'hA5A5A5A5);

    // Abort while idx4 is stalled in SEND.
    out_ready = 0;
    first_idx = 5'd4; last_idx = 5'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("abort_pre_idx", {27'd0, out_idx}, 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) n_done++;
      step();
    end
    chk("abort_no_done", n_done, 32'd0);

    // start together with abort in IDLE is dropped.
    start = 1'b1; abort = 1'b1; first_idx = 5'd0; last_idx = 5'd0;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    chk("startabort_busy",  {31'd0, busy},      32'd0);
    chk("startabort_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle during FETCH.
    out_ready = 1'b1;
    first_idx = 5'd9; last_idx = 5'd12; start = 1'b1;
    step();
    start = 1'b0;
    chk("arst_pre_busy", {31'd0, busy},    32'd1);
    chk("arst_pre_addr", {27'd0, rf_addr}, 32'd9);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy",  {31'd0, busy},      32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_done",  {31'd0, done},      32'd0);
    chk("arst_addr",  {27'd0, rf_addr},   32'd0);
    chk("arst_idx",   {27'd0, out_idx},   32'd0);
    chk("arst_data",  out_data,           32'd0);
    step();
    reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid || busy || done) cyc++;
      step();
    end
    chk("arst_quiet_after", cyc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
